dm_responder: RTL and testbench



---
 rtl/dm_responder.sv | 66 ++++++
 tb/tb_dm_responder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: single-port data memory with read latency, zero-clear, backdoor load and collision counter
module dm_responder #(
  parameter int ADDR_W = 14,
  parameter int DEPTH = 16384,
  parameter int READ_LAT = 1,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_WEB,
  input  logic [31:0]       DM_BWEB,
  input  logic [ADDR_W-1:0] DM_A,
  input  logic [31:0]       DM_IN,
  output logic [31:0]       DM_OUT,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              init_done,
  output logic [15:0]       collision_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [AW-1:0] clr_addr, a, la;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd1, rd2;
  logic ready, cpu_wr, collide;
  assign a = DM_A[AW-1:0];
  assign la = load_addr[AW-1:0];
  assign ready = state == READY;
  assign cpu_wr = ready && !DM_WEB && DM_BWEB != '1;
  assign collide = cpu_wr && load_en;
  assign init_done = ready;
  assign DM_OUT = READ_LAT == 2 ? rd2 : rd1;
  always_comb begin
    state_n = state;
    if (state == CLEAR && clr_addr == AW'(DEPTH - 1)) state_n = READY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_addr <= '0;
    end else begin
      state <= state_n;
      clr_addr <= state == CLEAR ? clr_addr + 1'b1 : clr_addr;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_addr] <= '0;
      else if (load_en) mem[la] <= load_data;
      else if (cpu_wr) mem[a] <= (mem[a] & DM_BWEB) | (DM_IN & ~DM_BWEB);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1 <= '0;
      rd2 <= '0;
      collision_cnt <= '0;
    end else begin
      rd1 <= !ready ? '0 : DM_WEB ? mem[a] : rd1;
      rd2 <= rd1;
      if (collide && collision_cnt != '1) collision_cnt <= collision_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized self-check of dm_responder at both read latencies against a memory model
module tb_dm_responder;
  localparam int AW = 14, D = 16;
  logic clk = 0, rst = 0, web = 1, len = 0;
  logic [31:0] bweb = '1, din = 0, ld = 0;
  logic [AW-1:0] a = 0, la = 0;
  logic [31:0] out1, out2;
  logic done1, done2;
  logic [15:0] cnt1, cnt2;
  logic [31:0] mem_m [D];
  logic [31:0] e1, e2;
  logic [15:0] ecnt;
  logic rdy;
  int left, n;
  int checks = 0, errors = 0;
  dm_responder #(.ADDR_W(AW), .DEPTH(D), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .DM_WEB(web), .DM_BWEB(bweb), .DM_A(a), .DM_IN(din), .DM_OUT(out1),
    .load_en(len), .load_addr(la), .load_data(ld), .init_done(done1), .collision_cnt(cnt1));
  dm_responder #(.ADDR_W(AW), .DEPTH(D), .READ_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst(rst), .DM_WEB(web), .DM_BWEB(bweb), .DM_A(a), .DM_IN(din), .DM_OUT(out2),
    .load_en(len), .load_addr(la), .load_data(ld), .init_done(done2), .collision_cnt(cnt2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic compare();
    check("out_lat1", out1, e1);
    check("out_lat2", out2, e2);
    check("init_done1", {31'd0, done1}, {31'd0, rdy});
    check("init_done2", {31'd0, done2}, {31'd0, rdy});
    check("coll_cnt1", {16'd0, cnt1}, {16'd0, ecnt});
    check("coll_cnt2", {16'd0, cnt2}, {16'd0, ecnt});
  endtask
  task automatic cyc(input logic w, input logic [31:0] bw, input logic [AW-1:0] ad, input logic [31:0] d,
                     input logic l, input logic [AW-1:0] lad, input logic [31:0] ldd);
    web = w; bweb = bw; a = ad; din = d; len = l; la = lad; ld = ldd;
    @(posedge clk);
    e2 = e1;
    if (!rdy) begin
      e1 = 0;
      left--;
      if (left == 0) rdy = 1;
    end else begin
      if (w) e1 = mem_m[ad % D];
      if (l) begin
        mem_m[lad % D] = ldd;
        if (!w && bw != '1 && ecnt != 16'hffff) ecnt++;
      end else if (!w) mem_m[ad % D] = (mem_m[ad % D] & bw) | (d & ~bw);
    end
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset();
    rst = 1; web = 1; len = 0;
    @(posedge clk);
    e1 = 0; e2 = 0; ecnt = 0; rdy = 0; left = D;
    foreach (mem_m[i]) mem_m[i] = 0;
    @(negedge clk);
    rst = 0;
    compare();
  endtask
  task automatic rd(input logic [AW-1:0] ad);
    cyc(1, '1, ad, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [AW-1:0] ad, input logic [31:0] d, input logic [31:0] bw);
    cyc(0, bw, ad, d, 0, 0, 0);
  endtask
  task automatic rnd();
    logic [31:0] bw;
    int r;
    r = $urandom_range(0, 3);
    bw = r == 0 ? '1 : r == 1 ? '0 : $urandom;
    cyc(1'($urandom_range(0, 1)), bw, AW'($urandom_range(0, 31)), $urandom,
        $urandom_range(0, 4) == 0, AW'($urandom_range(0, 31)), $urandom);
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    n = 0;
    while (!done1 && n < 100) begin
      if (n < 3) cyc(0, 0, 2, 32'h55, 1, 2, 32'h66);
      else rnd();
      n++;
    end
    check("clear_len", n, 16);
    for (int i = 0; i < D; i++) rd(AW'(i));
    rd(2);
    check("clear_addr2", out1, 0);
    do_reset();
    repeat (5) rnd();
    do_reset();
    n = 0;
    while (!done1 && n < 100) begin
      rnd();
      n++;
    end
    check("restart_clear_len", n, 16);
    cyc(1, '1, 0, 0, 1, 3, 32'haabbccdd);
    wr(3, 32'h11223344, 32'hffff0000);
    rd(3);
    check("masked_lat1", out1, 32'haabb3344);
    rd(0);
    check("masked_lat2", out2, 32'haabb3344);
    wr(5, 32'h12345678, 0);
    rd(5);
    check("b2b_read", out1, 32'h12345678);
    wr(9, 32'h0, 32'h0);
    check("b2b_hold", out1, 32'h12345678);
    cyc(0, 0, 8, 32'h1, 1, 7, 32'hdeadbeef);
    check("collision_cnt", {16'd0, cnt1}, 1);
    rd(7);
    check("collision_load", out1, 32'hdeadbeef);
    rd(8);
    check("collision_drop", out1, 0);
    cyc(0, '1, 8, 32'h1, 1, 7, 32'h1234);
    check("no_collision_cnt", {16'd0, cnt1}, 1);
    cyc(1, '1, 7, 0, 1, 7, 32'h5a5a5a5a);
    check("load_read_old", out1, 32'h1234);
    wr(14'h13, 32'hcafe, 0);
    rd(3);
    check("wrap_alias", out1, 32'hcafe);
    repeat (500) rnd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
